// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the fpdiv request/response front end.
// Binary32 special-result encodings and flag bit positions.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    RESP
  } state_t;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  localparam int DIVZERO = 0;
  localparam int INVALID = 1;
  localparam int TIMEOUT = 2;

endpackage

// File: rtl/fpdiv_special.sv
// Detects a zero divisor and builds the local special result
// (signed infinity for x/0, quiet NaN for 0/0).
module fpdiv_special
  import fpdiv_pkg::*;
(
  input  logic [31:0] n,
  input  logic [31:0] d,
  output logic        bypass,
  output logic [31:0] quotient,
  output logic [2:0]  flags
);

  logic sign;

  assign sign = n[31] ^ d[31];

  always_comb begin
    bypass   = (d[30:0] == 31'd0);
    quotient = '0;
    flags    = '0;
    if (n[30:0] == 31'd0) begin
      quotient       = QNAN;
      flags[INVALID] = 1'b1;
    end else begin
      quotient       = {sign, INF_MAG};
      flags[DIVZERO] = 1'b1;
    end
  end

endmodule

// File: rtl/fpdiv_req_resp.sv
// Valid/ready front end for the iterative fpdiv core.
// Define FPDIV_TIMEOUT_EN to add a BUSY-state watchdog.
module fpdiv_req_resp
  import fpdiv_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  input  logic [1:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  output logic             core_start,
  output logic [WIDTH-1:0] core_dividend,
  output logic [WIDTH-1:0] core_divisor,
  output logic [1:0]       core_rm,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_quotient,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_quotient,
  output logic [TAG_W-1:0] resp_tag,
  output logic [2:0]       resp_flags,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] n_q, n_n;
  logic [WIDTH-1:0] d_q, d_n;
  logic [WIDTH-1:0] quo_q, quo_n;
  logic [1:0]       rm_q, rm_n;
  logic [TAG_W-1:0] tag_q, tag_n;
  logic [2:0]       flags_q, flags_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic             sp_bypass;
  logic [WIDTH-1:0] sp_quo;
  logic [2:0]       sp_flags;

`ifdef FPDIV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_n;
`else
  logic unused_tmo;
  assign unused_tmo = |TIMEOUT_CYC;
`endif

  fpdiv_special u_special (
    .n        (req_dividend),
    .d        (req_divisor),
    .bypass   (sp_bypass),
    .quotient (sp_quo),
    .flags    (sp_flags)
  );

  always_comb begin
    state_n = state_q;
    n_n     = n_q;
    d_n     = d_q;
    rm_n    = rm_q;
    tag_n   = tag_q;
    quo_n   = quo_q;
    flags_n = flags_q;
    cnt_n   = cnt_q;
`ifdef FPDIV_TIMEOUT_EN
    tmo_n   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          n_n   = req_dividend;
          d_n   = req_divisor;
          rm_n  = req_rm;
          tag_n = req_tag;
          if (sp_bypass) begin
            quo_n   = sp_quo;
            flags_n = sp_flags;
            state_n = RESP;
          end else begin
            state_n = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        state_n = BUSY;
`ifdef FPDIV_TIMEOUT_EN
        tmo_n   = '0;
`endif
      end
      BUSY: begin
        // a done arriving with the watchdog expiry still wins
        if (core_done) begin
          quo_n   = core_quotient;
          flags_n = '0;
          state_n = RESP;
        end
`ifdef FPDIV_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          quo_n          = QNAN;
          flags_n        = '0;
          flags_n[TIMEOUT] = 1'b1;
          state_n        = RESP;
        end else begin
          tmo_n = tmo_q + TW'(1);
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
          if (cnt_q != '1) cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      rm_q    <= '0;
      tag_q   <= '0;
      quo_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
`ifdef FPDIV_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      n_q     <= n_n;
      d_q     <= d_n;
      rm_q    <= rm_n;
      tag_q   <= tag_n;
      quo_q   <= quo_n;
      flags_q <= flags_n;
      cnt_q   <= cnt_n;
`ifdef FPDIV_TIMEOUT_EN
      tmo_q   <= tmo_n;
`endif
    end
  end

  assign req_ready     = reset && (state_q == IDLE);
  assign core_start    = (state_q == LAUNCH);
  assign core_dividend = n_q;
  assign core_divisor  = d_q;
  assign core_rm       = rm_q;
  assign resp_valid    = (state_q == RESP);
  assign resp_quotient = quo_q;
  assign resp_tag      = tag_q;
  assign resp_flags    = flags_q;
  assign op_count      = cnt_q;

endmodule

// File: tb/tb_fpdiv_req_resp.sv
// Scoreboard bench for fpdiv_req_resp with a stub iterative core.
// Define FPDIV_TIMEOUT_EN to also exercise the watchdog.
module tb_fpdiv_req_resp;

  localparam int TMO = 64;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  tag;
    logic [2:0]  fl;
  } exp_t;

  logic        clk = 0;
  logic        reset = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic [31:0] req_dividend = 0;
  logic [31:0] req_divisor = 0;
  logic [1:0]  req_rm = 0;
  logic [3:0]  req_tag = 0;
  logic        core_start;
  logic [31:0] core_dividend;
  logic [31:0] core_divisor;
  logic [1:0]  core_rm;
  logic        core_done = 0;
  logic [31:0] core_quotient = 0;
  logic        resp_valid;
  logic        resp_ready = 0;
  logic [31:0] resp_quotient;
  logic [3:0]  resp_tag;
  logic [2:0]  resp_flags;
  logic [15:0] op_count;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  int starts = 0;
  int exp_starts = 0;
  int exp_cnt = 0;
  int lat = 12;
  bit stub_en = 1;
  bit rr_force = 1;
  bit rr_val = 1;

  fpdiv_req_resp #(
    .WIDTH(32), .TAG_W(4), .TIMEOUT_CYC(TMO), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_rm(req_rm), .req_tag(req_tag),
    .core_start(core_start), .core_dividend(core_dividend),
    .core_divisor(core_divisor), .core_rm(core_rm),
    .core_done(core_done), .core_quotient(core_quotient),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_tag(resp_tag),
    .resp_flags(resp_flags), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Stand-in for the core's arithmetic: 1.0 divisor returns N.
  function automatic logic [31:0] core_fn(input logic [31:0] n,
                                          input logic [31:0] d);
    if (d == 32'h3F80_0000) return n;
    return n ^ {d[15:0], d[31:16]};
  endfunction

  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d,
                                 input logic [3:0] tag, input bit tmo);
    exp_t e;
    e.tag = tag;
    if (d[30:0] == 0 && n[30:0] == 0) begin
      e.q = 32'h7FC0_0000; e.fl = 3'b010;
    end else if (d[30:0] == 0) begin
      e.q = {n[31] ^ d[31], 31'h7F80_0000}; e.fl = 3'b001;
    end else if (tmo) begin
      e.q = 32'h7FC0_0000; e.fl = 3'b100;
    end else begin
      e.q = core_fn(n, d); e.fl = 3'b000;
    end
    return e;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      resp_ready = rr_force ? rr_val : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int l;
    logic [31:0] sn, sd;
    forever begin
      @(negedge clk);
      if (core_start && stub_en && reset) begin
        sn = core_dividend;
        sd = core_divisor;
        l = lat;
        @(posedge clk);
        repeat (l - 1) @(posedge clk);
        #1;
        core_done = 1;
        core_quotient = core_fn(sn, sd);
        @(posedge clk);
        #1;
        core_done = 0;
        core_quotient = $urandom;
      end
    end
  end

  // Monitor: pops the scoreboard on every response handshake.
  initial begin
    exp_t e;
    bit have_prev = 0;
    logic [31:0] pq;
    logic [3:0] pt;
    logic [2:0] pf;
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_cnt = 0;
        have_prev = 0;
      end else begin
        if (core_start) starts++;
        if (have_prev && resp_valid) begin
          chk("hold_quotient", resp_quotient, pq);
          chk("hold_tag", 32'(resp_tag), 32'(pt));
          chk("hold_flags", 32'(resp_flags), 32'(pf));
        end
        if (resp_valid && resp_ready) begin
          have_prev = 0;
          if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(resp_valid), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("quotient", resp_quotient, e.q);
            chk("tag", 32'(resp_tag), 32'(e.tag));
            chk("flags", 32'(resp_flags), 32'(e.fl));
            chk("op_count", 32'(op_count), 32'(exp_cnt));
          end
          if (exp_cnt < 65535) exp_cnt++;
        end else if (resp_valid) begin
          have_prev = 1;
          pq = resp_quotient; pt = resp_tag; pf = resp_flags;
        end else begin
          have_prev = 0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] n, input logic [31:0] d,
                      input logic [1:0] rm, input logic [3:0] tag,
                      input bit tmo);
    int k = 0;
    sb.push_back(model(n, d, tag, tmo));
    if (d[30:0] != 0) exp_starts++;
    req_dividend = n; req_divisor = d; req_rm = rm; req_tag = tag;
    req_valid = 1;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready && k < 500);
    if (!req_ready) chk("req_accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || !req_ready) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) chk("idle_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] n, d;
    logic [15:0] cnt0;
    int k;
    bit seen;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_quotient", resp_quotient, 32'd0);
    chk("rst_tag", 32'(resp_tag), 32'd0);
    chk("rst_flags", 32'(resp_flags), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_core_n", core_dividend, 32'd0);
    @(posedge clk);
    #1;

    // normal path through the core
    lat = 12;
    send(32'h4040_0000, 32'h3F80_0000, 2'd1, 4'd5, 0);
    chk("start_after_accept", 32'(core_start), 32'd1);
    chk("launch_rm", 32'(core_rm), 32'd1);
    wait_idle();
    chk("op_count_one", 32'(op_count), 32'd1);

    // divide by zero, both signs, and 0/0
    send(32'h3F80_0000, 32'h8000_0000, 2'd0, 4'd1, 0);
    chk("dz_no_start", 32'(core_start), 32'd0);
    chk("dz_resp_next", 32'(resp_valid), 32'd1);
    wait_idle();
    send(32'hBF80_0000, 32'h8000_0000, 2'd0, 4'd2, 0);
    chk("dz2_resp_next", 32'(resp_valid), 32'd1);
    wait_idle();
    send(32'h8000_0000, 32'h0000_0000, 2'd0, 4'd3, 0);
    chk("zz_no_start", 32'(core_start), 32'd0);
    chk("zz_resp_next", 32'(resp_valid), 32'd1);
    wait_idle();

    // backpressure with a request waiting behind the response
    rr_val = 0;
    send(32'h4000_0000, 32'h4080_0000, 2'd2, 4'd7, 0);
    k = 0;
    while (!resp_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("bp_resp_seen", 32'(resp_valid), 32'd1);
    sb.push_back(model(32'h3F80_0000, 32'h0000_0000, 4'd9, 0));
    req_dividend = 32'h3F80_0000; req_divisor = 0; req_tag = 4'd9;
    req_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_valid_high", 32'(resp_valid), 32'd1);
    end
    cnt0 = op_count;
    @(posedge clk);
    #1 rr_val = 1;
    @(posedge clk);
    #1;
    chk("bp_count_inc", 32'(op_count), 32'(cnt0 + 16'd1));
    chk("bp_ready_back", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 0;
    chk("bp_pending_taken", 32'(resp_valid), 32'd1);
    wait_idle();

    // reset while the core is busy
    lat = 12;
    send(32'h4110_0000, 32'h4040_0000, 2'd0, 4'd4, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    chk("rstbusy_no_resp", 32'(seen), 32'd0);
    chk("rstbusy_count", 32'(op_count), 32'd0);
    chk("rstbusy_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

`ifdef FPDIV_TIMEOUT_EN
    stub_en = 0;
    send(32'h4000_0000, 32'h4040_0000, 2'd0, 4'd6, 1);
    k = 0;
    while (!resp_valid && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("tmo_cycles", 32'(k), 32'(TMO + 1));
    wait_idle();
    stub_en = 1;
`endif

    // randomized traffic with random backpressure
    rr_force = 0;
    for (int i = 0; i < 40; i++) begin
      n = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = {d[31], 31'd0};
      if ($urandom_range(0, 3) == 0) n = {n[31], 31'd0};
      lat = $urandom_range(1, 15);
      send(n, d, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0);
    end
    wait_idle();
    chk("start_count", 32'(starts), 32'(exp_starts));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
